chunked_addsub: RTL

Parametrised multi-cycle adder/subtractor: the sequential successor to the team's 32-bit combinational adder with carry-in, carry-out and signed overflow. It processes a WIDTH-bit operand pair CHUNK bits per clock through one narrow carry chain, trading latency for area. It adds subtract mode and a start/busy/done handshake. It sits in the arithmetic datapath of the adders/multipliers chip, alongside the multiplier blocks.

---
 rtl/arith_pkg.sv | 19 +
 rtl/chunked_addsub_if.sv | 25 ++
 rtl/chunked_addsub_chunk_adder.sv | 18 +
 rtl/chunked_addsub.sv | 108 ++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: FSM state encoding and chunk-count helpers.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int calc_nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Index register needs at least one bit even when there is a single chunk.
    function automatic int calc_idx_w(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/chunked_addsub_if.sv
// Request/result bundle for chunked_addsub; master issues operands, slave returns results.
interface chunked_addsub_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/chunked_addsub_chunk_adder.sv
// Combinational CHUNK-bit adder with carry-in and carry-out.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);
    logic [CHUNK:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        s     = total[CHUNK-1:0];
        cout  = total[CHUNK];
    end
endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice of the operands per clock
// through a single narrow carry chain, with start/busy/done handshake.
module chunked_addsub
    import arith_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    chunked_addsub_if.slave  bus
);
    localparam int NCH  = calc_nch(WIDTH, CHUNK);
    localparam int IDXW = calc_idx_w(NCH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    if (WIDTH % CHUNK != 0) begin : g_width_chk
        $fatal(1, "chunked_addsub: WIDTH must be a multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] ca_a, ca_b, ca_s;
    logic             ca_co;

    assign ca_a = opa_q[idx_q*CHUNK +: CHUNK];
    assign ca_b = opb_q[idx_q*CHUNK +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a    (ca_a),
        .b    (ca_b),
        .cin  (carry_q),
        .s    (ca_s),
        .cout (ca_co)
    );

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    opa_d   = bus.a;
                    opb_d   = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*CHUNK +: CHUNK] = ca_s;
                carry_d = ca_co;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    // Overflow is judged on the stored (already inverted) operand B.
                    cout_d  = ca_co;
                    ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                              (sum_d[WIDTH-1] != opa_q[WIDTH-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
